// File: rtl/pipe_hazard_if.sv
// Stall, hazard and stage-control signal bundle between the RV32 pipeline
// stages and the central hazard sequencer.
interface pipe_hazard_if;
  logic       stall_from_ID;
  logic       stall_from_EX;
  logic       stall_from_MEM;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken_ex;

  logic       if_en;
  logic       id_en;
  logic       ex_en;
  logic       mem_en;
  logic       wb_en;
  logic       flush_if_id;
  logic       bubble_ex;
  logic       bubble_mem;
  logic       pc_redirect;

  // Pipeline side: raises stall and hazard information, consumes stage controls.
  modport master (
    output stall_from_ID, stall_from_EX, stall_from_MEM,
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_rd, ex_mem_read, branch_taken_ex,
    input  if_en, id_en, ex_en, mem_en, wb_en,
    input  flush_if_id, bubble_ex, bubble_mem, pc_redirect
  );

  modport slave (
    input  stall_from_ID, stall_from_EX, stall_from_MEM,
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_rd, ex_mem_read, branch_taken_ex,
    output if_en, id_en, ex_en, mem_en, wb_en,
    output flush_if_id, bubble_ex, bubble_mem, pc_redirect
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: stall arbitration, load-use bubbles,
// branch flush FSM and MEM-stall watchdog. Perf counters built with HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_if.slave     hz,
  output logic [1:0]       state_out,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01
  } state_e;

  localparam int              WD_W     = $clog2(MAX_STALL + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_STALL + 1);
  localparam logic [2:0]      FC_INIT  = 3'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            load_use;

  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
  end

  // Stage controls are gated by rst_n so that every enable drops the moment
  // reset asserts, not at the next edge.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    hz.if_en       = 1'b0;
    hz.id_en       = 1'b0;
    hz.ex_en       = 1'b0;
    hz.mem_en      = 1'b0;
    hz.wb_en       = 1'b0;
    hz.flush_if_id = 1'b0;
    hz.bubble_ex   = 1'b0;
    hz.bubble_mem  = 1'b0;
    hz.pc_redirect = 1'b0;

    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (hz.stall_from_MEM) begin
            // Full freeze; a branch in EX stays put and is seen again later.
          end else if (hz.stall_from_EX) begin
            hz.mem_en     = 1'b1;
            hz.wb_en      = 1'b1;
            hz.bubble_mem = 1'b1;
          end else if (hz.branch_taken_ex) begin
            hz.if_en       = 1'b1;
            hz.id_en       = 1'b1;
            hz.ex_en       = 1'b1;
            hz.mem_en      = 1'b1;
            hz.wb_en       = 1'b1;
            hz.pc_redirect = 1'b1;
            hz.flush_if_id = 1'b1;
            hz.bubble_ex   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FC_INIT;
            end
          end else if (load_use || hz.stall_from_ID) begin
            hz.ex_en     = 1'b1;
            hz.mem_en    = 1'b1;
            hz.wb_en     = 1'b1;
            hz.bubble_ex = 1'b1;
          end else begin
            hz.if_en  = 1'b1;
            hz.id_en  = 1'b1;
            hz.ex_en  = 1'b1;
            hz.mem_en = 1'b1;
            hz.wb_en  = 1'b1;
          end
        end

        FLUSH: begin
          if (hz.stall_from_MEM) begin
            // Frozen with the counter held.
          end else if (hz.stall_from_EX) begin
            hz.mem_en     = 1'b1;
            hz.wb_en      = 1'b1;
            hz.bubble_mem = 1'b1;
          end else begin
            hz.if_en       = 1'b1;
            hz.id_en       = 1'b1;
            hz.ex_en       = 1'b1;
            hz.mem_en      = 1'b1;
            hz.wb_en       = 1'b1;
            hz.flush_if_id = 1'b1;
            hz.bubble_ex   = 1'b1;
            flush_cnt_d    = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
              state_d     = RUN;
              flush_cnt_d = 3'd0;
            end
          end
        end

        default: begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // Watchdog counts consecutive MEM-stall cycles and saturates at the limit.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!hz.stall_from_MEM) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    timeout_d = timeout_q || (wd_cnt_d == WD_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state_out     = state_q;
  assign stall_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!hz.if_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (hz.pc_redirect && (flush_events_q != '1)) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MAX_STALL=255);
// perf-counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state_out;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .MAX_STALL   (255),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hz),
    .state_out    (state_out),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  function automatic logic [4:0] enables();
    return {hz.if_en, hz.id_en, hz.ex_en, hz.mem_en, hz.wb_en};
  endfunction

  // {flush_if_id, bubble_ex, bubble_mem, pc_redirect}
  function automatic logic [3:0] controls();
    return {hz.flush_if_id, hz.bubble_ex, hz.bubble_mem, hz.pc_redirect};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZ_PERF_CNT_EN
    check_output({tag, "_stall_cycles"}, stall_cycles, 32'(exp_stall));
    check_output({tag, "_flush_events"}, flush_events, 32'(exp_flush));
`else
    check_output({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    check_output({tag, "_flush_events"}, flush_events, 32'd0);
`endif
  endtask

  task automatic apply_stimulus(input logic mem, input logic ex, input logic id,
                                input logic br, input logic ld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    hz.stall_from_MEM  = mem;
    hz.stall_from_EX   = ex;
    hz.stall_from_ID   = id;
    hz.branch_taken_ex = br;
    hz.ex_mem_read     = ld;
    hz.ex_rd           = rd;
    hz.id_rs1          = rs1;
    hz.id_rs1_used     = u1;
    hz.id_rs2          = rs2;
    hz.id_rs2_used     = u2;
    #1;
  endtask

  task automatic apply_idle();
    apply_stimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs forced low even with a branch request present
    apply_stimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("rst_en", 32'(enables()), 32'h00);
    check_output("rst_ctl", 32'(controls()), 32'h0);
    check_output("rst_state", 32'(state_out), 32'h0);
    check_output("rst_timeout", 32'(stall_timeout), 32'h0);
    check_perf("rst");

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_idle();
    check_output("post_rst_en", 32'(enables()), 32'h1f);
    check_output("post_rst_ctl", 32'(controls()), 32'h0);
    tick();

    // Load-use on rs1
    apply_stimulus(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
    check_output("lu_rs1_en", 32'(enables()), 32'h07);
    check_output("lu_rs1_ctl", 32'(controls()), 32'h4);
    exp_stall++;
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd0, 0);
    check_output("lu_release_en", 32'(enables()), 32'h1f);
    check_output("lu_release_ctl", 32'(controls()), 32'h0);

    // Load-use on rs2 only; unused rs1 match is not a hazard
    apply_stimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 1);
    check_output("lu_rs2_en", 32'(enables()), 32'h07);
    apply_stimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 0);
    check_output("lu_unused_en", 32'(enables()), 32'h1f);
    apply_stimulus(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 1);
    exp_stall++;
    tick();

    // x0 destination never creates a hazard
    apply_stimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
    check_output("lu_x0_en", 32'(enables()), 32'h1f);
    check_output("lu_x0_ctl", 32'(controls()), 32'h0);
    tick();

    // ID stall
    apply_stimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("id_stall_en", 32'(enables()), 32'h07);
    check_output("id_stall_ctl", 32'(controls()), 32'h4);
    exp_stall++;
    tick();

    // EX stall beats branch and ID stall
    apply_stimulus(0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("ex_stall_en", 32'(enables()), 32'h03);
    check_output("ex_stall_ctl", 32'(controls()), 32'h2);
    exp_stall++;
    tick();
    check_output("ex_stall_state", 32'(state_out), 32'h0);

    // MEM + EX: full freeze
    apply_stimulus(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("mem_ex_en", 32'(enables()), 32'h00);
    check_output("mem_ex_ctl", 32'(controls()), 32'h0);
    exp_stall++;
    tick();

    // MEM stall hides a taken branch
    apply_stimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("mem_br_en", 32'(enables()), 32'h00);
    check_output("mem_br_ctl", 32'(controls()), 32'h0);
    exp_stall++;
    tick();
    check_output("mem_br_state", 32'(state_out), 32'h0);

    // Taken branch: redirect cycle, one flush cycle, back to RUN
    apply_stimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("br0_en", 32'(enables()), 32'h1f);
    check_output("br0_ctl", 32'(controls()), 32'hd);
    exp_flush++;
    tick();
    apply_idle();
    check_output("br1_state", 32'(state_out), 32'h1);
    check_output("br1_en", 32'(enables()), 32'h1f);
    check_output("br1_ctl", 32'(controls()), 32'hc);
    tick();
    check_output("br2_state", 32'(state_out), 32'h0);
    check_output("br2_ctl", 32'(controls()), 32'h0);
    check_perf("br2");

    // Branch, then MEM stall for 3 cycles inside FLUSH
    apply_stimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    exp_flush++;
    tick();
    apply_stimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 3; i++) begin
      check_output("flush_mem_en", 32'(enables()), 32'h00);
      check_output("flush_mem_ctl", 32'(controls()), 32'h0);
      check_output("flush_mem_state", 32'(state_out), 32'h1);
      exp_stall++;
      tick();
    end
    // A load-use pattern and a branch are ignored while flushing
    apply_stimulus(0, 0, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    check_output("flush_resume_state", 32'(state_out), 32'h1);
    check_output("flush_resume_en", 32'(enables()), 32'h1f);
    check_output("flush_resume_ctl", 32'(controls()), 32'hc);
    tick();
    apply_idle();
    check_output("flush_done_state", 32'(state_out), 32'h0);
    check_perf("flush_mem");

    // EX stall inside FLUSH
    apply_stimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    exp_flush++;
    tick();
    apply_stimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    check_output("flush_ex_en", 32'(enables()), 32'h03);
    check_output("flush_ex_ctl", 32'(controls()), 32'h2);
    exp_stall++;
    tick();
    apply_idle();
    check_output("flush_ex_state", 32'(state_out), 32'h1);
    tick();
    check_output("flush_ex_done", 32'(state_out), 32'h0);

    // Watchdog: 256 consecutive MEM-stall cycles
    apply_stimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 255; i++) begin
      tick();
    end
    exp_stall += 255;
    check_output("wd_255", 32'(stall_timeout), 32'h0);
    tick();
    exp_stall++;
    check_output("wd_256", 32'(stall_timeout), 32'h1);
    apply_idle();
    tick();
    check_output("wd_sticky", 32'(stall_timeout), 32'h1);
    check_perf("wd");

    // Reset in the middle of FLUSH
    apply_stimulus(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    apply_idle();
    check_output("mid_flush_state", 32'(state_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_state", 32'(state_out), 32'h0);
    check_output("async_rst_en", 32'(enables()), 32'h00);
    check_output("async_rst_ctl", 32'(controls()), 32'h0);
    check_output("async_rst_timeout", 32'(stall_timeout), 32'h0);
    exp_stall = 0;
    exp_flush = 0;
    check_perf("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("rerun_state", 32'(state_out), 32'h0);
    check_output("rerun_en", 32'(enables()), 32'h1f);
    check_output("rerun_ctl", 32'(controls()), 32'h0);
    tick();
    check_output("rerun_next_state", 32'(state_out), 32'h0);
    check_perf("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Collects stage stall requests (stall_from_ID/EX/MEM), detects load-use hazards, and handles taken-branch redirects.
- Produces per-stage advance enables, bubble/flush controls and a PC redirect pulse.
- One instance per core.

Parameters:
- FLUSH_CYCLES, 2, total wrong-path bubble cycles after a taken branch (legal 1..7).
- MAX_STALL, 255, consecutive MEM-stall cycles tolerated before the watchdog fires.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_from_ID  in  1  ID stage cannot accept/advance
- stall_from_EX  in  1  EX multi-cycle op busy
- stall_from_MEM  in  1  MEM waiting on memory
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- branch_taken_ex  in  1  EX resolved a taken branch/jump
- if_en, id_en, ex_en, mem_en, wb_en  out  1 each  stage register load enables
- flush_if_id  out  1  clear IF/ID register to NOP
- bubble_ex  out  1  load NOP into ID/EX register
- bubble_mem  out  1  load NOP into EX/MEM register
- pc_redirect  out  1  select branch target into PC this cycle
- state_out  out  2  FSM state (00 RUN, 01 FLUSH)
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  perf counter (optional feature)
- flush_events  out  CNT_W  perf counter (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State forced to RUN, flush counter 0, watchdog count 0, stall_timeout 0, perf counters 0.
  - All outputs 0, including all enables.
  - Normal operation resumes on the first clk edge after release.
- Control outputs are combinational from registered state plus current inputs. State, counters and flags are registered.
- Load-use hazard (LU) = ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
- RUN, evaluated in strict priority order:
  1. stall_from_MEM: all five enables 0, no bubbles, no redirect. A simultaneous branch_taken_ex is ignored this cycle; EX is frozen, so the branch is re-presented after release.
  2. stall_from_EX: if/id/ex_en=0, mem_en=wb_en=1, bubble_mem=1.
  3. branch_taken_ex: all enables 1, pc_redirect=1, flush_if_id=1, bubble_ex=1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  4. LU or stall_from_ID: if_en=id_en=0, ex/mem/wb_en=1, bubble_ex=1.
  5. Otherwise all enables 1, all bubbles/flush 0.
- FLUSH:
  - All enables 1, flush_if_id=1, bubble_ex=1, pc_redirect=0. Counter decrements each cycle; at 1→0, go to RUN.
  - stall_from_MEM or stall_from_EX: same enable pattern as in RUN, flush outputs 0, counter frozen.
  - branch_taken_ex and LU are ignored (EX holds a bubble).
- Watchdog:
  - Counts consecutive cycles with stall_from_MEM=1 and clears on any cycle without it.
  - When the count reaches MAX_STALL+1, stall_timeout sets and stays set until reset.
  - The watchdog count saturates.
- Simultaneous stall_from_MEM and stall_from_EX: the MEM rule wins (full freeze).

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each cycle with if_en=0 while out of reset.
  - flush_events increments on each pc_redirect pulse.
  - Both saturate at all-ones.
- Undefined: both ports are still present, driven constant 0, and no counter flops are built.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → one cycle with if_en=id_en=0, bubble_ex=1; next cycle (ex_mem_read=0) all enables 1.
- ex_mem_read=1, ex_rd=0, id_rs1=0 used → no stall; all enables 1, bubble_ex=0.
- FLUSH_CYCLES=2, branch_taken_ex pulse → cycle0: pc_redirect=1, flush_if_id=bubble_ex=1, state→01; cycle1: flush outputs 1, pc_redirect=0, state→00; cycle2: clean RUN; flush_events=1.
- In FLUSH, stall_from_MEM held 3 cycles → all enables 0 for 3 cycles, state stays 01; then exactly one more flush cycle, then RUN; stall_cycles=3.
- stall_from_MEM held 256 cycles, MAX_STALL=255 → stall_timeout rises after the 256th stalled cycle; remains 1 after the stall drops, until rst_n pulse.
- rst_n asserted mid-FLUSH → immediately state_out=00, all outputs 0, counters 0; after release, first cycle is RUN with all enables 1.
